// File: rtl/fifo_stream_drain_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_drain_pkg
// Shared constants for the FIFO read-side drain stage. The defaults match the
// upstream synchronous FIFO word width and a four-entry output buffer.
// The lvl_width helper sizes level counters that must also represent "full".
// -----------------------------------------------------------------------------
package fifo_stream_drain_pkg;

   localparam int DRAIN_DATA_WIDTH = 16;
   localparam int DRAIN_BUF_DEPTH  = 4;
   localparam int DRAIN_CNT_WIDTH  = 16;

   // A level counter for `depth` entries must hold 0..depth inclusive.
   function automatic int lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : fifo_stream_drain_pkg

// File: rtl/fifo_stream_drain_buf.sv
// -----------------------------------------------------------------------------
// drain_buf
// Circular output buffer for the drain stage. It holds words returned by the
// FIFO until the stream consumer accepts them.
// Ports:
//   clk, rst     clock; asynchronous active-high reset (pointers and level)
//   wr_en_i      write wr_data_i at the tail (caller guarantees a free slot)
//   wr_data_i    word to append
//   rd_en_i      consumer accept; pops the head when the buffer is non-empty
//   head_o       word at the head, zero when the buffer is empty
//   level_o      number of buffered words, 0..DEPTH
// -----------------------------------------------------------------------------
module drain_buf
   import fifo_stream_drain_pkg::*;
#(
   parameter int DATA_WIDTH = DRAIN_DATA_WIDTH,
   parameter int DEPTH      = DRAIN_BUF_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en_i,
   input  logic [DATA_WIDTH-1:0]         wr_data_i,
   input  logic                          rd_en_i,
   output logic [DATA_WIDTH-1:0]         head_o,
   output logic [lvl_width(DEPTH)-1:0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = lvl_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  do_pop;

   assign do_pop = rd_en_i & (level_q != '0);

   // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Simultaneous write and pop leaves the level unchanged.
      unique case ({wr_en_i, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: storage is deliberately not reset; the level gates what is visible, so stale contents never escape.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign head_o  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign level_o = level_q;

endmodule : drain_buf

// File: rtl/fifo_stream_drain.sv
// -----------------------------------------------------------------------------
// fifo_stream_drain
// Read-side stage directly downstream of the synchronous FIFO. It pops words
// through the FIFO's registered read port and presents them as a valid/ready
// stream. A credit count (buffered words plus the word in flight) ensures every
// issued read has a buffer slot waiting, so backpressure never loses data.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   drain_en         permits new FIFO reads
//   fifo_empty       FIFO empty flag
//   fifo_data_out    FIFO read data, valid one cycle after fifo_rd_en
//   fifo_underflow   FIFO underflow flag, aligned with fifo_data_out
//   fifo_rd_en       FIFO pop request
//   m_valid/m_data   stream output (buffer head), m_ready downstream accept
//   buf_level        buffered word count
//   words_cnt        accepted handshakes, saturating
//   underflow_err    sticky: a returning word was flagged as underflow
// -----------------------------------------------------------------------------
module fifo_stream_drain
   import fifo_stream_drain_pkg::*;
#(
   parameter int DATA_WIDTH = DRAIN_DATA_WIDTH,
   parameter int BUF_DEPTH  = DRAIN_BUF_DEPTH,
   parameter int CNT_WIDTH  = DRAIN_CNT_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              drain_en,
   input  logic                              fifo_empty,
   input  logic [DATA_WIDTH-1:0]             fifo_data_out,
   input  logic                              fifo_underflow,
   output logic                              fifo_rd_en,
   output logic                              m_valid,
   output logic [DATA_WIDTH-1:0]             m_data,
   input  logic                              m_ready,
   output logic [lvl_width(BUF_DEPTH)-1:0]   buf_level,
   output logic [CNT_WIDTH-1:0]              words_cnt,
   output logic                              underflow_err
);

   localparam int                 LVL_W   = lvl_width(BUF_DEPTH);
   localparam logic [LVL_W:0]     DEPTH_C = (LVL_W+1)'(BUF_DEPTH);

   logic                 inflight_q;
   logic                 underflow_err_q, underflow_err_d;
   logic [CNT_WIDTH-1:0] words_cnt_q, words_cnt_d;
   logic [LVL_W:0]       credit;
   logic                 capture, drop, handshake;

   // Credits count buffered words plus the word returning next edge; one extra
   // bit keeps the sum from wrapping when the buffer is full.
   assign credit     = {1'b0, buf_level} + {{LVL_W{1'b0}}, inflight_q};
   // No m_ready term here: read issue depends only on registered occupancy.
   // rst gates the request so a reset never pops a word it would then discard.
   assign fifo_rd_en = ~rst & drain_en & ~fifo_empty & (credit < DEPTH_C);

   assign capture    = inflight_q & ~fifo_underflow;
   assign drop       = inflight_q &  fifo_underflow;
   assign m_valid    = (buf_level != '0);
   assign handshake  = m_valid & m_ready;

   drain_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (capture),
      .wr_data_i (fifo_data_out),
      .rd_en_i   (m_ready),
      .head_o    (m_data),
      .level_o   (buf_level)
   );

   always_comb begin
      underflow_err_d = underflow_err_q | drop;
      words_cnt_d     = words_cnt_q;
      if (handshake && (words_cnt_q != '1)) words_cnt_d = words_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q      <= 1'b0;
         underflow_err_q <= 1'b0;
         words_cnt_q     <= '0;
      end else begin
         inflight_q      <= fifo_rd_en;
         underflow_err_q <= underflow_err_d;
         words_cnt_q     <= words_cnt_d;
      end
   end

   assign words_cnt     = words_cnt_q;
   assign underflow_err = underflow_err_q;

endmodule : fifo_stream_drain
